instr_fetch_unit: RTL

Fetch stage feeding the decode control unit. Holds the program counter, issues word requests to instruction memory over a valid/ready request channel, buffers returned words in a small in-order FIFO, and presents them to decode as `instr`/`instr_pc` with a valid/ready handshake. Taken branches and jumps resolved downstream arrive as a redirect that flushes the buffer and discards in-flight responses.

---
 rtl/instr_fetch_unit_if.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit signal bundle (imem request/response, redirect, decode)
//
// Purpose: groups every handshake and bus signal of the fetch stage so the
// unit and its environment connect through one port.
//
// Signals (direction as seen from the fetch unit, modport master):
//   imem_req_valid   out  fetch request present
//   imem_req_ready   in   memory accepts the request this cycle
//   imem_req_addr    out  word-aligned fetch address
//   imem_resp_valid  in   response word present, always accepted, in order
//   imem_resp_data   in   instruction word returned by memory
//   redirect_valid   in   single-cycle control-flow redirect pulse
//   redirect_pc      in   redirect target, bits [1:0] ignored
//   instr_valid      out  instr/instr_pc hold a valid instruction
//   instr_ready      in   decode consumes the instruction this cycle
//   instr            out  instruction word at the buffer head
//   instr_pc         out  address of instr
//
// Modports: master = fetch unit, slave = memory/decode/branch environment.

interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output instr_valid,
        output instr,
        output instr_pc,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with credit-limited buffer and redirect flush
//
// Purpose: holds the fetch PC, issues word requests to instruction memory,
// buffers returned words in order together with their PC, and hands them to
// decode. A redirect flushes the buffer, retargets the PC, and marks every
// request still in flight as stale so its response is thrown away.
//
// Parameters:
//   RESET_PC    PC loaded on reset, word aligned
//   FIFO_DEPTH  buffer entries and request credit limit, power of two, >= 2
//
// Ports:
//   clk   in  clock, all state updates on the rising edge
//   rst   in  synchronous active-high reset
//   bus   instr_fetch_unit_if.master, see the interface file for signals

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int unsigned PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] pending_q,  pending_d;
    logic [CW-1:0] drop_q,     drop_d;
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;

    // Addresses of accepted requests, oldest first; occupancy always equals
    // pending, so it needs no count of its own.
    logic [PW-1:0] aq_rd_q, aq_rd_d;
    logic [PW-1:0] aq_wr_q, aq_wr_d;

    logic [31:0] aq_mem_q   [FIFO_DEPTH];
    logic [31:0] word_mem_q [FIFO_DEPTH];
    logic [31:0] pc_mem_q   [FIFO_DEPTH];

    logic credit_ok;
    logic req_valid;
    logic req_fire;
    logic resp_take;
    logic resp_push;
    logic out_valid;
    logic pop;

    // A request is only issued when a buffer slot is reserved for its
    // response, so a response can always be pushed without a full check.
    assign credit_ok = ({1'b0, pending_q} + {1'b0, count_q}) < DEPTH_W;
    assign req_valid = !rst && credit_ok;
    assign req_fire  = req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a memory protocol error and is
    // ignored completely so the bookkeeping cannot underflow.
    assign resp_take = bus.imem_resp_valid && (pending_q != '0);

    // Stale responses are those counted in drop, plus anything arriving in
    // the redirect cycle itself (its PC belongs to the old path).
    assign resp_push = resp_take && (drop_q == '0) && !bus.redirect_valid;

    assign out_valid = !rst && (count_q != '0);
    assign pop       = out_valid && bus.instr_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
    assign bus.instr_valid    = out_valid;
    assign bus.instr          = out_valid ? word_mem_q[rd_ptr_q] : 32'd0;
    assign bus.instr_pc       = out_valid ? pc_mem_q[rd_ptr_q]   : 32'd0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        pending_d = pending_q + CW'(req_fire) - CW'(resp_take);
        drop_d    = drop_q - CW'(resp_take && (drop_q != '0));
        count_d   = count_q + CW'(resp_push) - CW'(pop);

        wr_ptr_d  = wr_ptr_q + PW'(resp_push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        aq_wr_d   = aq_wr_q + PW'(req_fire);
        aq_rd_d   = aq_rd_q + PW'(resp_take);

        if (bus.redirect_valid) begin
            // Masking keeps the target word aligned whatever decode sends.
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            // After a redirect every request still outstanding (including
            // one accepted this cycle) belongs to the old path. Earlier stale
            // requests are already part of pending, so drop becomes exactly
            // the remaining in-flight count rather than accumulating.
            drop_d     = pending_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            pending_q  <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
        end
    end

    // Storage arrays carry no reset: their contents are only observed when
    // the matching count/pointer says an entry is live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_mem_q[aq_wr_q] <= fetch_pc_q;
        end
        if (resp_push) begin
            word_mem_q[wr_ptr_q] <= bus.imem_resp_data;
            pc_mem_q[wr_ptr_q]   <= aq_mem_q[aq_rd_q];
        end
    end

endmodule
